// File: rtl/dec_onehot_seq.sv
// Registered N-to-2^N one-hot decoder with a direct mode and an auto-scan mode.
// In scan mode each line stays active for a programmable dwell time.
module dec_onehot_seq #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic               mode,
  input  logic [N-1:0]       sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               clr,
  output logic [2**N-1:0]    out,
  output logic [N-1:0]       idx,
  output logic               wrap,
  output logic               busy
);

  localparam int LINES = 2 ** N;
  localparam logic [LINES-1:0] ONE = LINES'(1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt;
  logic [N-1:0]       idx_next;

  assign idx_next = idx + N'(1);

  function automatic logic [LINES-1:0] decode(input logic [N-1:0] i);
    decode = ONE << i;
  endfunction

  // The dwell counter only advances on cycles where a line is actually shown,
  // so the first enabled edge after a blanked period restores the frozen line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      idx       <= '0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      dwell_reg <= '0;
      cnt       <= '0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        state <= IDLE;
        out   <= '0;
        busy  <= 1'b0;
      end else if (load) begin
        idx <= sel;
        out <= en ? decode(sel) : '0;
        if (mode) begin
          state     <= SCAN;
          busy      <= 1'b1;
          dwell_reg <= dwell;
          cnt       <= '0;
        end else begin
          state <= DIRECT;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          DIRECT: out <= en ? decode(idx) : '0;
          SCAN: begin
            if (!en) begin
              out <= '0;
            end else if (~|out) begin
              out <= decode(idx);
            end else if (cnt == dwell_reg) begin
              cnt  <= '0;
              idx  <= idx_next;
              out  <= decode(idx_next);
              wrap <= &idx;
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
          default: out <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed testbench for dec_onehot_seq: default instance plus N=1 and N=4 sweeps.
module tb_dec_onehot_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] dwell = '0;
  logic       clr = 1'b0;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;
  logic       busy;

  logic       load1 = 1'b0;
  logic [0:0] sel1 = '0;
  logic [3:0] dwell1 = '0;
  logic [1:0] out1;
  logic [0:0] idx1;
  logic       wrap1;
  logic       busy1;

  logic       load4 = 1'b0;
  logic [3:0] sel4 = '0;
  logic [3:0] dwell4 = '0;
  logic [15:0] out4;
  logic [3:0] idx4;
  logic       wrap4;
  logic       busy4;

  int total = 0;
  int bad = 0;

  logic [7:0] scan_seq [12] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80,
                                8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02};

  always #5 clk = ~clk;

  dec_onehot_seq #(.N(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode), .sel(sel),
    .dwell(dwell), .clr(clr), .out(out), .idx(idx), .wrap(wrap), .busy(busy)
  );

  dec_onehot_seq #(.N(1), .DWELL_W(4)) dut_n1 (
    .clk(clk), .rst(rst), .en(en), .load(load1), .mode(mode), .sel(sel1),
    .dwell(dwell1), .clr(clr), .out(out1), .idx(idx1), .wrap(wrap1), .busy(busy1)
  );

  dec_onehot_seq #(.N(4), .DWELL_W(4)) dut_n4 (
    .clk(clk), .rst(rst), .en(en), .load(load4), .mode(mode), .sel(sel4),
    .dwell(dwell4), .clr(clr), .out(out4), .idx(idx4), .wrap(wrap4), .busy(busy4)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (out !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_hold: out=%h idx=%0d wrap=%b busy=%b required out=00 idx=0 wrap=0 busy=0",
                 out, idx, wrap, busy);
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (out !== 8'h00 || idx !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_after: out=%h idx=%0d busy=%b required out=00 idx=0 busy=0", out, idx, busy);
    end
  endtask

  task automatic test_direct();
    en = 1'b1;
    load = 1'b1; mode = 1'b0; sel = 3'd5;
    tick();
    load = 1'b0;
    total++;
    if (out !== 8'h20 || idx !== 3'd5 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL direct_load: out=%h idx=%0d busy=%b required out=20 idx=5 busy=0", out, idx, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (out !== 8'h20 || wrap !== 1'b0) begin
        bad++;
        $display("[TB] FAIL direct_hold[%0d]: out=%h wrap=%b required out=20 wrap=0", i, out, wrap);
      end
    end
  endtask

  task automatic test_scan();
    load = 1'b1; mode = 1'b1; sel = 3'd6; dwell = 8'd2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      total++;
      if (out !== scan_seq[i] || wrap !== (i == 6) || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL scan_seq[%0d]: out=%h wrap=%b busy=%b required out=%h wrap=%b busy=1",
                 i, out, wrap, busy, scan_seq[i], (i == 6));
      end
    end
  endtask

  task automatic test_fast_gating();
    logic [7:0] want;
    load = 1'b1; mode = 1'b1; sel = 3'd0; dwell = 8'd0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      want = 8'h01 << i;
      total++;
      if (out !== want || idx !== 3'(i)) begin
        bad++;
        $display("[TB] FAIL fast_step[%0d]: out=%h idx=%0d required out=%h idx=%0d", i, out, idx, want, i);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out !== 8'h00 || idx !== 3'd3 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL gate_off[%0d]: out=%h idx=%0d busy=%b required out=00 idx=3 busy=1", i, out, idx, busy);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = 8'h08 << i;
      total++;
      if (out !== want) begin
        bad++;
        $display("[TB] FAIL gate_resume[%0d]: out=%h required out=%h", i, out, want);
      end
    end
  endtask

  task automatic test_precedence();
    load = 1'b1; mode = 1'b1; sel = 3'd0; dwell = 8'd3;
    tick();
    load = 1'b0;
    repeat (3) tick();
    total++;
    if (out !== 8'h01) begin
      bad++;
      $display("[TB] FAIL prec_pre: out=%h required out=01", out);
    end
    // the dwell expires on this edge; the new load must win
    load = 1'b1; mode = 1'b1; sel = 3'd2; dwell = 8'd1;
    tick();
    load = 1'b0;
    total++;
    if (out !== 8'h04 || idx !== 3'd2) begin
      bad++;
      $display("[TB] FAIL prec_load_wins: out=%h idx=%0d required out=04 idx=2", out, idx);
    end
    tick();
    total++;
    if (out !== 8'h04) begin
      bad++;
      $display("[TB] FAIL prec_cnt_restart: out=%h required out=04", out);
    end
    tick();
    total++;
    if (out !== 8'h08 || idx !== 3'd3) begin
      bad++;
      $display("[TB] FAIL prec_advance: out=%h idx=%0d required out=08 idx=3", out, idx);
    end
    clr = 1'b1; load = 1'b1; mode = 1'b1; sel = 3'd5;
    tick();
    clr = 1'b0; load = 1'b0;
    total++;
    if (out !== 8'h00 || busy !== 1'b0 || idx !== 3'd3) begin
      bad++;
      $display("[TB] FAIL clr_beats_load: out=%h busy=%b idx=%0d required out=00 busy=0 idx=3", out, busy, idx);
    end
    tick();
    total++;
    if (out !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_stays: out=%h busy=%b required out=00 busy=0", out, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    load = 1'b1; mode = 1'b1; sel = 3'd6; dwell = 8'd1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    total++;
    if (out !== 8'h80 || wrap !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_pre: out=%h wrap=%b required out=80 wrap=0", out, wrap);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: out=%h idx=%0d wrap=%b busy=%b required out=00 idx=0 wrap=0 busy=0",
               out, idx, wrap, busy);
    end
    tick();
    total++;
    if (out !== 8'h00 || wrap !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_after: out=%h wrap=%b busy=%b required out=00 wrap=0 busy=0", out, wrap, busy);
    end
  endtask

  task automatic test_sweep_n1();
    int line;
    int wraps;
    logic [1:0] want;
    wraps = 0;
    load1 = 1'b1; mode = 1'b1; sel1 = 1'b0; dwell1 = 4'd15;
    tick();
    load1 = 1'b0;
    for (int j = 0; j <= 64; j++) begin
      if (j > 0) tick();
      line = (j / 16) % 2;
      want = 2'b01 << line;
      if (wrap1) wraps++;
      total++;
      if (out1 !== want || idx1 !== 1'(line) || wrap1 !== (j > 0 && j % 32 == 0)) begin
        bad++;
        $display("[TB] FAIL sweep_n1[%0d]: out=%b idx=%0d wrap=%b required out=%b idx=%0d wrap=%b",
                 j, out1, idx1, wrap1, want, line, (j > 0 && j % 32 == 0));
      end
    end
    total++;
    if (wraps != 2) begin
      bad++;
      $display("[TB] FAIL sweep_n1_wraps: got %0d required 2", wraps);
    end
  endtask

  task automatic test_sweep_n4();
    int line;
    int wraps;
    logic [15:0] want;
    wraps = 0;
    load4 = 1'b1; mode = 1'b1; sel4 = 4'd0; dwell4 = 4'd15;
    tick();
    load4 = 1'b0;
    for (int j = 0; j <= 256; j++) begin
      if (j > 0) tick();
      line = (j / 16) % 16;
      want = 16'h0001 << line;
      if (wrap4) wraps++;
      total++;
      if (out4 !== want || idx4 !== 4'(line) || wrap4 !== (j == 256)) begin
        bad++;
        $display("[TB] FAIL sweep_n4[%0d]: out=%h idx=%0d wrap=%b required out=%h idx=%0d wrap=%b",
                 j, out4, idx4, wrap4, want, line, (j == 256));
      end
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("[TB] FAIL sweep_n4_wraps: got %0d required 1", wraps);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_fast_gating();
    test_precedence();
    test_reset_mid_scan();
    test_sweep_n1();
    test_sweep_n4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
